ahb5_bus_arbiter: RTL and testbench

- Round-robin AHB5 bus arbiter sharing one address/data bus among NUM_MASTERS master VIP instances.
- Sits between the master drivers and the slave side of the environment.
- Drives per-master grants, HMASTER and HMASTLOCK to the bus mux and slave.
- Tracks the current owner's burst so that grant handover happens only at legal AHB boundaries.

---
 rtl/ahb5_bus_arbiter_if.sv | 42 ++++
 rtl/ahb5_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb5_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ahb5_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// ahb5_bus_arbiter_if
//   Bundles the shared AHB5 request/grant signals between the master drivers
//   and the round-robin bus arbiter.
//
//   Signals
//     HBUSREQ   [NUM_MASTERS]      per-master bus request
//     HLOCK     [NUM_MASTERS]      per-master locked-transfer request
//     HTRANS    [2]                muxed transfer type of the address-phase owner
//     HBURST    [3]                muxed burst type of the address-phase owner
//     HREADY                       bus ready, transfer accepted when high
//     HGRANT    [NUM_MASTERS]      one-hot grant
//     HMASTER   [MASTER_ID_WIDTH]  index of the address-phase owner
//     HMASTLOCK                    current address phase is locked
//
//   Modports
//     master : requesting side (drives requests and bus status, sees grants)
//     slave  : arbiter side (sees requests and bus status, drives grants)
// -----------------------------------------------------------------------------
interface ahb5_bus_arbiter_if #(
    parameter int NUM_MASTERS     = 4,
    parameter int MASTER_ID_WIDTH = 2
);
    logic [NUM_MASTERS-1:0]     HBUSREQ;
    logic [NUM_MASTERS-1:0]     HLOCK;
    logic [1:0]                 HTRANS;
    logic [2:0]                 HBURST;
    logic                       HREADY;
    logic [NUM_MASTERS-1:0]     HGRANT;
    logic [MASTER_ID_WIDTH-1:0] HMASTER;
    logic                       HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb5_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ahb5_bus_arbiter
//   Round-robin AHB5 arbiter sharing one address/data bus among NUM_MASTERS
//   masters. It follows the owner's burst so that grant handover happens only
//   at legal AHB boundaries, and supports locked sequences.
//
//   Ports
//     HCLK    in   bus clock, all state updates on the rising edge
//     HRESET  in   synchronous active-high reset
//     bus     slave modport of ahb5_bus_arbiter_if
//               in : HBUSREQ, HLOCK, HTRANS, HBURST, HREADY
//               out: HGRANT (one-hot), HMASTER, HMASTLOCK
//
//   The "owner" throughout is the currently granted master.
// -----------------------------------------------------------------------------
module ahb5_bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int MASTER_ID_WIDTH = 2,
    parameter int DEFAULT_MASTER  = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb5_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_t;

    localparam logic [MASTER_ID_WIDTH-1:0] DEF_ID    = MASTER_ID_WIDTH'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0]     DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    // Registered state and outputs
    state_t                     r_state;
    logic [3:0]                 r_beat_cnt;
    logic [MASTER_ID_WIDTH-1:0] r_rr_ptr;
    logic [MASTER_ID_WIDTH-1:0] r_grant_idx;
    logic [NUM_MASTERS-1:0]     r_grant;
    logic [MASTER_ID_WIDTH-1:0] r_master;
    logic                       r_mastlock;

    // Combinational next-state terms
    logic                       w_owner_req;
    logic                       w_owner_lock;
    logic [3:0]                 w_burst_m1;
    logic [3:0]                 w_cnt_next;
    state_t                     w_cnt_state;
    logic                       w_beat;
    logic                       w_last_fixed;
    logic                       w_arb_point;
    logic                       w_found;
    logic [MASTER_ID_WIDTH-1:0] w_cand;
    logic [MASTER_ID_WIDTH-1:0] w_winner;
    logic [NUM_MASTERS-1:0]     w_winner_onehot;

    // Burst length minus one for a NONSEQ load
    always_comb begin
        w_burst_m1 = 4'd0;
        case (bus.HBURST)
            3'd0, 3'd1: w_burst_m1 = 4'd0;   // SINGLE, INCR
            3'd2, 3'd3: w_burst_m1 = 4'd3;   // WRAP4, INCR4
            3'd4, 3'd5: w_burst_m1 = 4'd7;   // WRAP8, INCR8
            default:    w_burst_m1 = 4'd15;  // WRAP16, INCR16
        endcase
    end

    // Beat counter update and the ARB/BURST state it implies
    always_comb begin
        w_cnt_next  = r_beat_cnt;
        w_cnt_state = (r_beat_cnt != 4'd0) ? ST_BURST : ST_ARB;
        case (bus.HTRANS)
            TR_IDLE: begin
                w_cnt_next  = 4'd0;
                w_cnt_state = ST_ARB;
            end
            TR_BUSY: begin
                w_cnt_next = r_beat_cnt;
            end
            TR_NONSEQ: begin
                w_cnt_next  = w_burst_m1;
                w_cnt_state = (w_burst_m1 != 4'd0) ? ST_BURST : ST_ARB;
            end
            default: begin
                // SEQ: an INCR beat sits at zero and stays there
                w_cnt_next  = (r_beat_cnt != 4'd0) ? (r_beat_cnt - 4'd1) : 4'd0;
                w_cnt_state = (r_beat_cnt > 4'd1) ? ST_BURST : ST_ARB;
            end
        endcase
    end

    // Arbitration point detection
    always_comb begin
        w_owner_req  = bus.HBUSREQ[r_grant_idx];
        w_owner_lock = bus.HLOCK[r_grant_idx];
        w_beat       = (bus.HTRANS == TR_NONSEQ) || (bus.HTRANS == TR_SEQ);
        w_last_fixed = (r_state == ST_BURST) && (bus.HTRANS == TR_SEQ) && (r_beat_cnt == 4'd1);
        if (r_state == ST_LOCKED) begin
            // Only an unlocked IDLE releases a locked owner
            w_arb_point = bus.HREADY && (bus.HTRANS == TR_IDLE) && !w_owner_lock;
        end else begin
            // An INCR owner still requesting keeps the bus beat by beat
            w_arb_point = bus.HREADY &&
                          ((bus.HTRANS == TR_IDLE) ||
                           (w_beat && (w_cnt_next == 4'd0) && !w_owner_req) ||
                           w_last_fixed);
        end
    end

    // Round-robin search starting just after the last requesting winner
    always_comb begin
        w_found  = 1'b0;
        w_winner = DEF_ID;
        w_cand   = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            w_cand = MASTER_ID_WIDTH'((32'(r_rr_ptr) + k) % 32'(NUM_MASTERS));
            if (!w_found && bus.HBUSREQ[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_winner_onehot = NUM_MASTERS'(1) << w_winner;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_ARB;
            r_beat_cnt  <= '0;
            r_rr_ptr    <= DEF_ID;
            r_grant_idx <= DEF_ID;
            r_grant     <= DEF_GRANT;
            r_master    <= DEF_ID;
            r_mastlock  <= 1'b0;
        end else if (bus.HREADY) begin
            r_beat_cnt <= w_cnt_next;
            // HMASTER/HMASTLOCK follow the grant one accepted cycle later
            r_master   <= r_grant_idx;
            r_mastlock <= bus.HLOCK[r_grant_idx];
            if (w_arb_point && w_owner_lock) begin
                // Owner asks for a lock at a boundary: keep the grant
                r_state <= ST_LOCKED;
            end else if (w_arb_point) begin
                r_state     <= w_cnt_state;
                r_grant_idx <= w_winner;
                r_grant     <= w_winner_onehot;
                if (w_found) begin
                    r_rr_ptr <= w_winner;
                end
            end else if (r_state != ST_LOCKED) begin
                r_state <= w_cnt_state;
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb5_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb5_bus_arbiter
//   Directed bench for ahb5_bus_arbiter with four masters. Inputs are driven
//   1 time unit after each rising edge and outputs are sampled at the same
//   point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_ahb5_bus_arbiter;

    localparam int NM  = 4;
    localparam int IDW = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic HCLK = 1'b0;
    logic HRESET;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned owned;

    ahb5_bus_arbiter_if #(.NUM_MASTERS(NM), .MASTER_ID_WIDTH(IDW)) bus ();

    ahb5_bus_arbiter #(
        .NUM_MASTERS(NM),
        .MASTER_ID_WIDTH(IDW),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
        bus.HREADY  = rdy;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [1:0] m, input logic ml);
        chk({tag, ".grant"},  32'(bus.HGRANT),    32'(g));
        chk({tag, ".master"}, 32'(bus.HMASTER),   32'(m));
        chk({tag, ".lock"},   32'(bus.HMASTLOCK), 32'(ml));
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        tick();
        HRESET = 1'b0;
    endtask

    // M2 is granted, runs one INCR8, M0 requests from beat 3, and 'waits'
    // wait states are inserted while beat 5 is presented.
    task automatic run_incr8(input string tag, input int unsigned waits);
        do_reset();
        drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        tick();
        expect_out({tag, ".g1"}, 4'b0100, 2'd0, 1'b0);
        tick();
        expect_out({tag, ".g2"}, 4'b0100, 2'd2, 1'b0);
        owned = 0;
        for (int unsigned b = 1; b <= 8; b++) begin
            if (b == 5) begin
                for (int unsigned w = 0; w < waits; w++) begin
                    drive(4'b0101, 4'b0000, SEQ, INCR8, 1'b0);
                    if (bus.HMASTER == 2'd2) owned++;
                    tick();
                    chk({tag, ".wait_cnt"}, 32'(dut.r_beat_cnt), 32'd4);
                    expect_out({tag, ".wait"}, 4'b0100, 2'd2, 1'b0);
                end
            end
            drive((b >= 3) ? 4'b0101 : 4'b0100, 4'b0000,
                  (b == 1) ? NONSEQ : SEQ, INCR8, 1'b1);
            if (bus.HMASTER == 2'd2) owned++;
            tick();
            chk({tag, ".cnt"}, 32'(dut.r_beat_cnt), 32'(8 - b));
            if (b < 8) chk({tag, ".held"}, 32'(bus.HGRANT), 32'b0100);
        end
        expect_out({tag, ".handover"}, 4'b0001, 2'd2, 1'b0);
        chk({tag, ".owned"}, 32'(owned), 32'(8 + waits));
        drive(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1);
        tick();
        expect_out({tag, ".m0"}, 4'b0001, 2'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state and idle hold
        do_reset();
        tick();
        expect_out("A.reset", 4'b0001, 2'd0, 1'b0);
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            expect_out("A.idle", 4'b0001, 2'd0, 1'b0);
        end

        // Masters 1 and 3 alternate with SINGLE + IDLE
        drive(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); expect_out("B.e1", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("B.e2", 4'b1000, 2'd1, 1'b0);
        drive(4'b1000, 4'b0000, NONSEQ, SINGLE, 1'b1);
        tick(); expect_out("B.e3", 4'b1000, 2'd3, 1'b0);
        drive(4'b0010, 4'b0000, NONSEQ, SINGLE, 1'b1);
        tick(); expect_out("B.e4", 4'b0010, 2'd3, 1'b0);
        drive(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); expect_out("B.e5", 4'b1000, 2'd1, 1'b0);
        drive(4'b0000, 4'b0000, NONSEQ, SINGLE, 1'b1);
        tick(); expect_out("B.e6", 4'b0001, 2'd3, 1'b0);
        tick(); expect_out("B.e7", 4'b0001, 2'd0, 1'b0);

        // INCR8 without and with wait states
        run_incr8("C", 0);
        run_incr8("D", 3);

        // Locked sequence of M1 with M2 requesting
        do_reset();
        drive(4'b0010, 4'b0010, IDLE, SINGLE, 1'b1);
        tick(); expect_out("E.e1", 4'b0010, 2'd0, 1'b0);
        tick(); expect_out("E.e2", 4'b0010, 2'd1, 1'b1);
        drive(4'b0110, 4'b0010, NONSEQ, SINGLE, 1'b1);
        tick(); expect_out("E.e3", 4'b0010, 2'd1, 1'b1);
        drive(4'b0110, 4'b0010, IDLE, SINGLE, 1'b1);
        tick(); expect_out("E.e4", 4'b0010, 2'd1, 1'b1);
        drive(4'b0110, 4'b0010, NONSEQ, SINGLE, 1'b1);
        tick(); expect_out("E.e5", 4'b0010, 2'd1, 1'b1);
        drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); expect_out("E.e6", 4'b0100, 2'd1, 1'b0);
        tick(); expect_out("E.e7", 4'b0100, 2'd2, 1'b0);

        // Reset in the middle of M3's INCR16
        do_reset();
        drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); expect_out("F.e1", 4'b1000, 2'd0, 1'b0);
        tick(); expect_out("F.e2", 4'b1000, 2'd3, 1'b0);
        drive(4'b1000, 4'b0000, NONSEQ, INCR16, 1'b1);
        tick(); chk("F.cnt15", 32'(dut.r_beat_cnt), 32'd15);
        drive(4'b1000, 4'b0000, SEQ, INCR16, 1'b1);
        HRESET = 1'b1;
        tick();
        expect_out("F.rst", 4'b0001, 2'd0, 1'b0);
        chk("F.rst_cnt", 32'(dut.r_beat_cnt), 32'd0);
        HRESET = 1'b0;
        // Pointer back at M0: M3 wins over M0 when both request
        drive(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); expect_out("F.rr", 4'b1000, 2'd0, 1'b0);
        chk("F.cnt0", 32'(dut.r_beat_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
